// File: rtl/cm0ik_sram_arbiter_if.sv
// SRAM arbiter bus bundle: bridge port, secondary port and the physical SRAM port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface cm0ik_sram_arbiter_if #(
  parameter int AWIDTH = 12
);
  logic [AWIDTH-3:0] B_RAMAD;
  logic [31:0]       B_RAMWD;
  logic              B_RAMCS;
  logic [3:0]        B_RAMWE;
  logic [31:0]       B_RAMRD;

  logic              S_REQ;
  logic [AWIDTH-3:0] S_ADDR;
  logic [31:0]       S_WDATA;
  logic [3:0]        S_WE;
  logic              S_GNT;
  logic              S_RVALID;
  logic [31:0]       S_RDATA;

  logic [31:0]       RAMRD;
  logic [AWIDTH-3:0] RAMAD;
  logic [31:0]       RAMWD;
  logic              RAMCS;
  logic [3:0]        RAMWE;

  modport slave (
    input  B_RAMAD, B_RAMWD, B_RAMCS, B_RAMWE,
    input  S_REQ, S_ADDR, S_WDATA, S_WE,
    input  RAMRD,
    output B_RAMRD, S_GNT, S_RVALID, S_RDATA,
    output RAMAD, RAMWD, RAMCS, RAMWE
  );

  modport master (
    output B_RAMAD, B_RAMWD, B_RAMCS, B_RAMWE,
    output S_REQ, S_ADDR, S_WDATA, S_WE,
    output RAMRD,
    input  B_RAMRD, S_GNT, S_RVALID, S_RDATA,
    input  RAMAD, RAMWD, RAMCS, RAMWE
  );
endinterface

// File: rtl/cm0ik_sram_arbiter.sv
// Fixed-priority SRAM port arbiter (bridge > zero-fill engine > secondary port)
// with a zero-fill init FSM and a starvation flag for the secondary requester.
module cm0ik_sram_arbiter #(
  parameter int AWIDTH       = 12,
  parameter int STARVE_LIMIT = 16
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic INITREQ,
  output logic INITBUSY,
  output logic INITDONE,
  output logic STARVE,
  cm0ik_sram_arbiter_if.slave bus
);

  localparam int WW = AWIDTH - 2;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, FILL, DONE} initState_t;

  initState_t     state_q, state_d;
  logic [WW-1:0]  wordCnt_q, wordCnt_d;
  logic [SW-1:0]  starveCnt_q, starveCnt_d;
  logic           sRvalid_q, sRvalid_d;
  logic           sGnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      wordCnt_q   <= '0;
      starveCnt_q <= '0;
      sRvalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wordCnt_q   <= wordCnt_d;
      starveCnt_q <= starveCnt_d;
      sRvalid_q   <= sRvalid_d;
    end
  end

  // The fill only advances in cycles the bridge leaves free, so no word is skipped.
  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (INITREQ) begin
          state_d   = FILL;
          wordCnt_d = '0;
        end
      end
      FILL: begin
        if (!bus.B_RAMCS) begin
          wordCnt_d = wordCnt_q + WW'(1);
          if (wordCnt_q == {WW{1'b1}}) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign INITBUSY = (state_q == FILL);
  assign INITDONE = (state_q == DONE);
  assign sGnt     = bus.S_REQ & ~bus.B_RAMCS & ~INITBUSY;

  always_comb begin
    bus.RAMAD = bus.B_RAMAD;
    bus.RAMWD = bus.B_RAMWD;
    bus.RAMCS = 1'b0;
    bus.RAMWE = 4'h0;
    if (bus.B_RAMCS) begin
      bus.RAMCS = 1'b1;
      bus.RAMWE = bus.B_RAMWE;
    end else if (INITBUSY) begin
      bus.RAMAD = wordCnt_q;
      bus.RAMWD = 32'h0;
      bus.RAMCS = 1'b1;
      bus.RAMWE = 4'hF;
    end else if (sGnt) begin
      bus.RAMAD = bus.S_ADDR;
      bus.RAMWD = bus.S_WDATA;
      bus.RAMCS = 1'b1;
      bus.RAMWE = bus.S_WE;
    end
  end

  // Synchronous SRAM: read data for a granted read arrives one cycle later.
  always_comb begin
    sRvalid_d   = sGnt & (bus.S_WE == 4'h0);
    starveCnt_d = starveCnt_q;
    if (!bus.S_REQ || sGnt) begin
      starveCnt_d = '0;
    end else if (starveCnt_q != SLIM) begin
      starveCnt_d = starveCnt_q + SW'(1);
    end
  end

  assign STARVE       = (starveCnt_q == SLIM);
  assign bus.S_GNT    = sGnt;
  assign bus.S_RVALID = sRvalid_q;
  assign bus.S_RDATA  = bus.RAMRD;
  assign bus.B_RAMRD  = bus.RAMRD;

endmodule

// File: tb/tb_cm0ik_sram_arbiter.sv
// Directed bench for cm0ik_sram_arbiter with a behavioural synchronous SRAM model.
module tb_cm0ik_sram_arbiter;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic INITREQ;
  logic INITBUSY, INITDONE, STARVE;

  int checkCount = 0;
  int passCount  = 0;

  cm0ik_sram_arbiter_if #(.AWIDTH(12)) bus ();

  cm0ik_sram_arbiter #(.AWIDTH(12), .STARVE_LIMIT(16)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .INITREQ  (INITREQ),
    .INITBUSY (INITBUSY),
    .INITDONE (INITDONE),
    .STARVE   (STARVE),
    .bus      (bus)
  );

  always #5 HCLK = ~HCLK;

  logic [31:0] mem [0:1023];
  logic [31:0] ramRdQ;

  always @(posedge HCLK) begin
    if (bus.RAMCS) begin
      for (int b = 0; b < 4; b++)
        if (bus.RAMWE[b]) mem[bus.RAMAD][b*8 +: 8] <= bus.RAMWD[b*8 +: 8];
      ramRdQ <= mem[bus.RAMAD];
    end
  end

  assign bus.RAMRD = ramRdQ;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic bCs, input logic [9:0] bAd, input logic [31:0] bWd,
                               input logic [3:0] bWe, input logic sReq, input logic [9:0] sAd,
                               input logic [31:0] sWd, input logic [3:0] sWe);
    bus.B_RAMCS = bCs;
    bus.B_RAMAD = bAd;
    bus.B_RAMWD = bWd;
    bus.B_RAMWE = bWe;
    bus.S_REQ   = sReq;
    bus.S_ADDR  = sAd;
    bus.S_WDATA = sWd;
    bus.S_WE    = sWe;
  endtask

  // Pulses INITREQ, then walks the fill one cycle at a time, optionally injecting bridge
  // reads every bridgeEvery-th cycle and a stray INITREQ when word reinitAt is written.
  // Returns at the first non-busy cycle or after stopAt busy cycles.
  task automatic runFill(input int bridgeEvery, input int reinitAt, input int stopAt,
                         output int cycles, output int bridges, output int seqErr,
                         output int words, output int doneDuring);
    int   k;
    logic pulsed;
    logic [9:0] addr;
    cycles = 0; bridges = 0; seqErr = 0; words = 0; doneDuring = 0; k = 0; pulsed = 1'b0;
    @(negedge HCLK);
    INITREQ = 1'b1;
    @(negedge HCLK);
    INITREQ = 1'b0;
    for (int it = 0; it < 4000; it++) begin
      addr = k[9:0];
      bus.B_RAMCS = (bridgeEvery > 0) && ((k % bridgeEvery) == bridgeEvery - 1);
      bus.B_RAMAD = addr;
      bus.B_RAMWD = 32'h0BAD_0BAD;
      bus.B_RAMWE = 4'h0;
      INITREQ = (reinitAt >= 0) && (words == reinitAt) && !pulsed;
      if (INITREQ) pulsed = 1'b1;
      #1;
      if (!INITBUSY || cycles == stopAt) break;
      cycles++;
      k++;
      if (INITDONE) doneDuring++;
      if (bus.B_RAMCS) begin
        bridges++;
        if (bus.RAMAD !== bus.B_RAMAD || bus.RAMWD !== bus.B_RAMWD ||
            bus.RAMCS !== 1'b1 || bus.RAMWE !== 4'h0) seqErr++;
      end else begin
        addr = words[9:0];
        if (bus.RAMCS !== 1'b1 || bus.RAMWE !== 4'hF || bus.RAMWD !== 32'h0 ||
            bus.RAMAD !== addr) seqErr++;
        words++;
      end
      @(negedge HCLK);
    end
    bus.B_RAMCS = 1'b0;
    INITREQ = 1'b0;
  endtask

  int cyc, br, err, wds, dd;

  initial begin
    HRESETn = 1'b0;
    INITREQ = 1'b0;
    applyStimulus(0, 10'h0, 32'h0, 4'h0, 0, 10'h0, 32'h0, 4'h0);
    repeat (2) @(negedge HCLK);
    #1;
    checkOutput("rst_initbusy", 32'(INITBUSY), 32'd0);
    checkOutput("rst_initdone", 32'(INITDONE), 32'd0);
    checkOutput("rst_starve",   32'(STARVE),   32'd0);
    checkOutput("rst_rvalid",   32'(bus.S_RVALID), 32'd0);
    checkOutput("rst_ramcs",    32'(bus.RAMCS), 32'd0);
    checkOutput("rst_ramwe",    32'(bus.RAMWE), 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Bridge passthrough and idle port
    @(negedge HCLK);
    applyStimulus(1, 10'h123, 32'hA5A5_5A5A, 4'h3, 0, 10'h0, 32'h0, 4'h0);
    #1;
    checkOutput("br_ramad", 32'(bus.RAMAD), 32'h123);
    checkOutput("br_ramwd", bus.RAMWD, 32'hA5A5_5A5A);
    checkOutput("br_ramcs", 32'(bus.RAMCS), 32'd1);
    checkOutput("br_ramwe", 32'(bus.RAMWE), 32'h3);
    @(negedge HCLK);
    applyStimulus(0, 10'h2AA, 32'h1111_2222, 4'hF, 0, 10'h0, 32'h0, 4'h0);
    #1;
    checkOutput("idle_ramcs", 32'(bus.RAMCS), 32'd0);
    checkOutput("idle_ramwe", 32'(bus.RAMWE), 32'd0);
    checkOutput("idle_ramad", 32'(bus.RAMAD), 32'h2AA);
    checkOutput("idle_ramwd", bus.RAMWD, 32'h1111_2222);
    applyStimulus(0, 10'h0, 32'h0, 4'h0, 0, 10'h0, 32'h0, 4'h0);

    // Plain fill
    runFill(0, -1, 5000, cyc, br, err, wds, dd);
    checkOutput("fill1_cycles", cyc, 32'd1024);
    checkOutput("fill1_seq",    err, 32'd0);
    checkOutput("fill1_words",  wds, 32'd1024);
    checkOutput("fill1_done",   32'(INITDONE), 32'd1);
    checkOutput("fill1_busy",   32'(INITBUSY), 32'd0);

    // Secondary read of a bridge-written word
    @(negedge HCLK);
    applyStimulus(1, 10'h005, 32'hDEAD_BEEF, 4'hF, 0, 10'h0, 32'h0, 4'h0);
    @(negedge HCLK);
    applyStimulus(0, 10'h0, 32'h0, 4'h0, 1, 10'h005, 32'h0, 4'h0);
    #1;
    checkOutput("srd_gnt",   32'(bus.S_GNT), 32'd1);
    checkOutput("srd_ramad", 32'(bus.RAMAD), 32'h005);
    checkOutput("srd_ramwe", 32'(bus.RAMWE), 32'h0);
    @(negedge HCLK);
    applyStimulus(0, 10'h0, 32'h0, 4'h0, 0, 10'h0, 32'h0, 4'h0);
    #1;
    checkOutput("srd_rvalid", 32'(bus.S_RVALID), 32'd1);
    checkOutput("srd_rdata",  bus.S_RDATA, 32'hDEAD_BEEF);
    checkOutput("srd_brrd",   bus.B_RAMRD, 32'hDEAD_BEEF);
    @(negedge HCLK);
    #1;
    checkOutput("srd_rvalid_1cyc", 32'(bus.S_RVALID), 32'd0);

    // Secondary full and partial writes, read back through the bridge
    @(negedge HCLK);
    applyStimulus(0, 10'h0, 32'h0, 4'h0, 1, 10'h009, 32'hCAFE_F00D, 4'hF);
    #1;
    checkOutput("swr_gnt", 32'(bus.S_GNT), 32'd1);
    @(negedge HCLK);
    applyStimulus(0, 10'h0, 32'h0, 4'h0, 1, 10'h009, 32'h1234_BEEF, 4'h3);
    #1;
    checkOutput("swr_no_rvalid", 32'(bus.S_RVALID), 32'd0);
    @(negedge HCLK);
    applyStimulus(1, 10'h009, 32'h0, 4'h0, 0, 10'h0, 32'h0, 4'h0);
    @(negedge HCLK);
    applyStimulus(0, 10'h0, 32'h0, 4'h0, 0, 10'h0, 32'h0, 4'h0);
    #1;
    checkOutput("swr_readback", bus.B_RAMRD, 32'hCAFE_BEEF);

    // Secondary starved by 20 bridge cycles, then granted on the first free cycle
    for (int w = 1; w <= 20; w++) begin
      @(negedge HCLK);
      applyStimulus(1, 10'h0, 32'h0, 4'h0, 1, 10'h005, 32'h0, 4'h0);
      #1;
      checkOutput($sformatf("starve_gnt_w%0d", w), 32'(bus.S_GNT), 32'd0);
      checkOutput($sformatf("starve_flag_w%0d", w), 32'(STARVE), (w > 16) ? 32'd1 : 32'd0);
    end
    @(negedge HCLK);
    applyStimulus(0, 10'h0, 32'h0, 4'h0, 1, 10'h005, 32'h0, 4'h0);
    #1;
    checkOutput("starve_free_gnt", 32'(bus.S_GNT), 32'd1);
    @(negedge HCLK);
    applyStimulus(0, 10'h0, 32'h0, 4'h0, 0, 10'h0, 32'h0, 4'h0);
    #1;
    checkOutput("starve_cleared", 32'(STARVE), 32'd0);
    checkOutput("starve_rvalid",  32'(bus.S_RVALID), 32'd1);
    checkOutput("starve_rdata",   bus.S_RDATA, 32'hDEAD_BEEF);

    // Fill with a bridge read every 4th cycle: 341 groups of 3 writes + 1 write
    runFill(4, -1, 5000, cyc, br, err, wds, dd);
    checkOutput("fill2_cycles",  cyc, 32'd1365);
    checkOutput("fill2_bridges", br,  32'd341);
    checkOutput("fill2_seq",     err, 32'd0);
    checkOutput("fill2_words",   wds, 32'd1024);
    checkOutput("fill2_donecl",  dd,  32'd0);
    checkOutput("fill2_done",    32'(INITDONE), 32'd1);

    // Stray INITREQ at word 300 is ignored
    runFill(0, 300, 5000, cyc, br, err, wds, dd);
    checkOutput("fill3_cycles", cyc, 32'd1024);
    checkOutput("fill3_seq",    err, 32'd0);
    checkOutput("fill3_done",   32'(INITDONE), 32'd1);

    // Reset at word 500 with a starved secondary request pending
    applyStimulus(0, 10'h0, 32'h0, 4'h0, 1, 10'h000, 32'h0, 4'h0);
    runFill(0, -1, 500, cyc, br, err, wds, dd);
    checkOutput("fill4_words",   wds, 32'd500);
    checkOutput("fill4_busy",    32'(INITBUSY), 32'd1);
    checkOutput("fill4_starved", 32'(STARVE), 32'd1);
    HRESETn = 1'b0;
    applyStimulus(0, 10'h0, 32'h0, 4'h0, 0, 10'h0, 32'h0, 4'h0);
    #1;
    checkOutput("rst500_busy",   32'(INITBUSY), 32'd0);
    checkOutput("rst500_done",   32'(INITDONE), 32'd0);
    checkOutput("rst500_starve", 32'(STARVE), 32'd0);
    checkOutput("rst500_ramcs",  32'(bus.RAMCS), 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    #1;
    checkOutput("post_rst_done", 32'(INITDONE), 32'd0);
    checkOutput("post_rst_busy", 32'(INITBUSY), 32'd0);
    runFill(0, -1, 5000, cyc, br, err, wds, dd);
    checkOutput("fill5_cycles", cyc, 32'd1024);
    checkOutput("fill5_seq",    err, 32'd0);
    checkOutput("fill5_done",   32'(INITDONE), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
